int_seq_divider: RTL

//   Sequential unsigned integer divider (restoring, radix-2): one quotient bit per cycle.

---
 rtl/int_seq_divider.sv | 134 +++++++++++++
 1 files changed

// File: rtl/int_seq_divider.sv
// Sequential unsigned restoring divider, radix-2: one quotient bit per cycle,
// valid/ready handshake on both sides with a single operation in flight.
module int_seq_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   s_d;
    logic [WIDTH:0]   t_d;
    logic             borrow_d;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;

    // Trial subtract: R < D always holds, so the shifted partial remainder
    // fits in WIDTH+1 bits and the top bit of the difference is the borrow.
    always_comb begin
        s_d      = {r_q, q_q[WIDTH-1]};
        t_d      = s_d + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
        borrow_d = t_d[WIDTH];
        if (borrow_d) begin
            r_d = s_d[WIDTH-1:0];
        end else begin
            r_d = t_d[WIDTH-1:0];
        end
        q_d = {q_q[WIDTH-2:0], ~borrow_d};
    end

    // Control FSM, iteration registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= {WIDTH{1'b0}};
            q_q         <= {WIDTH{1'b0}};
            d_q         <= {WIDTH{1'b0}};
            count_q     <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        r_q        <= {WIDTH{1'b0}};
                        q_q        <= dividend;
                        d_q        <= divisor;
                        count_q    <= CW'(WIDTH);
                        in_ready_q <= 1'b0;
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                        dbz_q       <= 1'b0;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    // A zero divisor lands here straight from IDLE with
                    // out_valid still low; publish the saturated result now.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        quotient_q  <= {WIDTH{1'b1}};
                        remainder_q <= q_q;
                        dbz_q       <= 1'b1;
                    end else if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
